// File: rtl/present80_round_ctrl.sv
// Round-serial PRESENT-80 encryption engine: one round per clock, key schedule in parallel,
// valid/ready handshake on both plaintext input and ciphertext output.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// RUN   | one cipher round plus key update per clock, busy high
// DONE  | ciphertext presented (whitened), held until out_ready
module present80_round_ctrl #(
   parameter int NROUNDS = 31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] pt,
   input  logic [79:0] key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] ct,
   output logic        busy
);

   generate
      if (NROUNDS < 1 || NROUNDS > 31) begin : g_bad_nrounds
         $error("present80_round_ctrl: NROUNDS must be within 1..31");
      end
   endgenerate

   localparam logic [4:0] RC_LAST = 5'(NROUNDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t      state;
   logic [63:0] st;
   logic [79:0] k;
   logic [4:0]  rc;
   logic [63:0] round_st;
   logic [79:0] k_rot;
   logic [79:0] k_next;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] sbox_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int n = 0; n < 16; n++) begin
         y[4*n +: 4] = sbox(x[4*n +: 4]);
      end
      return y;
   endfunction

   // Vectors are held with the hex MSB at bit 63; the bit permutation is symmetric
   // under that index reversal, so it is written directly in LSB-first form.
   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 4; j++) begin
            y[16*j+i] = x[4*i+j];
         end
      end
      return y;
   endfunction

   always_comb begin
      round_st        = p_layer(sbox_layer(st ^ k[79:16]));
      k_rot           = {k[18:0], k[79:19]};
      k_next          = k_rot;
      k_next[79:76]   = sbox(k_rot[79:76]);
      k_next[19:15]   = k_rot[19:15] ^ rc;
   end

   assign ct = out_valid ? (st ^ k[79:16]) : 64'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         st        <= '0;
         k         <= '0;
         rc        <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  st       <= pt;
                  k        <= key;
                  rc       <= 5'd1;
                  state    <= S_RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            S_RUN: begin
               st <= round_st;
               k  <= k_next;
               if (rc == RC_LAST) begin
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end else begin
                  rc <= rc + 5'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  rc        <= '0;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_present80_round_ctrl.sv
// Scoreboard bench for present80_round_ctrl: directed known-answer vectors, backpressure,
// mid-run reset, back-to-back blocks and randomized traffic against a bit-level reference model.
module tb_present80_round_ctrl;

   localparam int NR = 31;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] pt = '0;
   logic [79:0] key = '0;
   logic        in_ready;
   logic        out_valid;
   logic        busy;
   logic [63:0] ct;

   present80_round_ctrl #(.NROUNDS(NR)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .pt(pt),
      .key(key),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .ct(ct),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;
   logic [63:0] exp_q[$];
   int          acc_q[$];
   int          last_acc = 0;

   logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // Reference cipher on bit arrays indexed MSB-first (index 0 = leftmost hex bit).
   function automatic logic [63:0] ref_enc(input logic [63:0] p, input logic [79:0] kk, input int nr);
      logic s[64];
      logic t[64];
      logic kb[80];
      logic kt[80];
      logic [3:0] v;
      logic [4:0] rcv;
      logic [63:0] r;
      for (int i = 0; i < 64; i++) s[i] = p[63-i];
      for (int i = 0; i < 80; i++) kb[i] = kk[79-i];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int i = 0; i < 64; i++) s[i] = s[i] ^ kb[i];
         for (int n = 0; n < 16; n++) begin
            v = {s[4*n], s[4*n+1], s[4*n+2], s[4*n+3]};
            v = SB[v];
            {s[4*n], s[4*n+1], s[4*n+2], s[4*n+3]} = v;
         end
         for (int i = 0; i < 16; i++)
            for (int j = 0; j < 4; j++)
               t[16*j+i] = s[4*i+j];
         s = t;
         for (int i = 0; i < 80; i++) kt[i] = kb[(i + 61) % 80];
         kb = kt;
         v = {kb[0], kb[1], kb[2], kb[3]};
         v = SB[v];
         {kb[0], kb[1], kb[2], kb[3]} = v;
         rcv = 5'(rnd);
         for (int m = 0; m < 5; m++) kb[60+m] = kb[60+m] ^ rcv[4-m];
      end
      r = '0;
      for (int i = 0; i < 64; i++) r[63-i] = s[i] ^ kb[i];
      return r;
   endfunction

   // Monitor: samples on the falling edge, pops the scoreboard on every output handshake.
   logic        prev_ov = 1'b0;
   logic        held = 1'b0;
   logic [63:0] held_ct = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov <= 1'b0;
         held    <= 1'b0;
      end else begin
         chk("status_onehot", 80'($onehot({in_ready, busy, out_valid})), 80'd1);
         if (!out_valid) chk("ct_zero_outside_done", 80'(ct), 80'd0);
         if (held) begin
            chk("hold_out_valid", 80'(out_valid), 80'd1);
            chk("hold_ct", 80'(ct), 80'(held_ct));
         end
         if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) fail_now("out_valid without accepted block");
            else chk("latency", 80'(cyc - acc_q.pop_front()), 80'(NR));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected ciphertext");
            else chk("ct", 80'(ct), 80'(exp_q.pop_front()));
         end
         held    <= out_valid && !out_ready;
         held_ct <= ct;
         prev_ov <= out_valid;
      end
   end

   // Called right after a rising edge; returns right after the accepting edge.
   task automatic send(input logic [63:0] p, input logic [79:0] kk, input logic [63:0] e, input bit hold);
      int n;
      n = 0;
      pt = p;
      key = kk;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         fail_now("timeout waiting for in_ready");
      end else begin
         exp_q.push_back(e);
         acc_q.push_back(cyc + 1);
         last_acc = cyc + 1;
      end
      @(posedge clk);
      #1;
      if (!hold) begin
         in_valid = 1'b0;
         pt = {$urandom, $urandom};
         key = {$urandom, $urandom, 16'($urandom)};
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_now("timeout draining scoreboard");
      @(posedge clk);
      #1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a1;
      int a2;
      int n;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 80'(in_ready), 80'd1);
      chk("reset_out_valid", 80'(out_valid), 80'd0);
      chk("reset_busy", 80'(busy), 80'd0);
      chk("reset_ct", 80'(ct), 80'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Known-answer vectors
      send(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0);
      send(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b0);
      send({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 1'b0);
      send({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0);
      drain();

      // Backpressure with a competing input request
      out_ready = 1'b0;
      send(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0);
      n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) fail_now("timeout waiting for out_valid");
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("bp_in_ready", 80'(in_ready), 80'd0);
         chk("bp_out_valid", 80'(out_valid), 80'd1);
         chk("bp_ct", 80'(ct), 80'h5579C1387B228445);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_in_ready", 80'(in_ready), 80'd1);
      chk("bp_release_out_valid", 80'(out_valid), 80'd0);
      @(posedge clk);
      #1;

      // Reset in the middle of a run
      send(64'h0123456789ABCDEF, 80'h00112233445566778899, 64'h0, 1'b0);
      repeat (14) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      chk("midrst_in_ready", 80'(in_ready), 80'd1);
      chk("midrst_out_valid", 80'(out_valid), 80'd0);
      chk("midrst_busy", 80'(busy), 80'd0);
      @(posedge clk);
      #1;
      send(64'h0, 80'h0, 64'h5579C1387B228445, 1'b0);
      drain();

      // Back-to-back with in_valid and out_ready held high
      send(64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 1'b1);
      a1 = last_acc;
      send({64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 1'b1);
      a2 = last_acc;
      chk("b2b_spacing_1", 80'(a2 - a1), 80'(NR + 2));
      send({64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 1'b0);
      chk("b2b_spacing_2", 80'(last_acc - a2), 80'(NR + 2));
      drain();

      // Randomized blocks with random output backpressure
      fork
         begin
            logic [63:0] rp;
            logic [79:0] rk;
            for (int b = 0; b < 8; b++) begin
               rp = {$urandom, $urandom};
               rk = {$urandom, $urandom, 16'($urandom)};
               send(rp, rk, ref_enc(rp, rk, NR), 1'b0);
            end
         end
         begin
            repeat (300) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
